// File: rtl/tstate_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tstate_sequencer
// Description : T-state ring for the SAP-1 control unit. Produces a one-hot
//               six-bit timing vector (T0..T5), supports free-run and
//               single-instruction step modes, can end no-operation opcodes
//               after T3, parks in HALTED on HLT or on an external halt,
//               and reports instruction boundaries and a busy-cycle count.
//
// Ports
//   clk          in   1      system clock, rising edge
//   rst          in   1      synchronous reset, active-high, highest priority
//   run_mode     in   1      1 = free-run, 0 = step mode
//   step_req     in   1      one-instruction request, only looked at in IDLE
//   opcode       in   4      IR opcode, valid from T3 onward
//   halt         in   1      external halt request
//   t_states     out  6      registered one-hot T-state, zero in IDLE/HALTED
//   instr_done   out  1      final T-state of the current instruction
//   busy         out  1      a T-state is active
//   halted       out  1      sequencer is parked in HALTED
//   cycle_count  out  CNT_W  number of busy cycles, saturating
//
// Revision    : 1.0  initial release
// ============================================================================
module tstate_sequencer #(
    parameter logic       EARLY_END = 1'b1,
    parameter logic [3:0] HLT_OP    = 4'b1111,
    parameter int         CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_mode,
    input  logic             step_req,
    input  logic [3:0]       opcode,
    input  logic             halt,
    output logic [5:0]       t_states,
    output logic             instr_done,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_T0     = 3'd1;
    localparam logic [2:0] S_T1     = 3'd2;
    localparam logic [2:0] S_T2     = 3'd3;
    localparam logic [2:0] S_T3     = 3'd4;
    localparam logic [2:0] S_T4     = 3'd5;
    localparam logic [2:0] S_T5     = 3'd6;
    localparam logic [2:0] S_HALTED = 3'd7;

    // One-hot T-state patterns
    localparam logic [5:0] c_T0   = 6'b000001;
    localparam logic [5:0] c_T1   = 6'b000010;
    localparam logic [5:0] c_T2   = 6'b000100;
    localparam logic [5:0] c_T3   = 6'b001000;
    localparam logic [5:0] c_T4   = 6'b010000;
    localparam logic [5:0] c_T5   = 6'b100000;
    localparam logic [5:0] c_NONE = 6'b000000;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [5:0]       r_t_states;
    logic [5:0]       w_next_t_states;
    logic [CNT_W-1:0] r_cycle_count;

    logic             w_op_used;
    logic             w_early_end;
    logic             w_busy;
    logic             w_halted;
    logic             w_instr_done;
    logic             w_cnt_max;

    // ------------------------------------------------------------------------
    // Opcode classification. Only LDA/ADD/SUB/OUT-style opcodes and the two
    // top opcodes need T4/T5; everything else does nothing after fetch and
    // may end once T3 has been reached.
    // ------------------------------------------------------------------------
    always_comb begin
        w_op_used = 1'b0;
        case (opcode)
            4'b0000, 4'b0001, 4'b0010, 4'b0011,
            4'b1110, 4'b1111: w_op_used = 1'b1;
            default:          w_op_used = 1'b0;
        endcase
    end

    assign w_early_end = EARLY_END && !w_op_used;

    // ------------------------------------------------------------------------
    // Process 1: state register. The T-state vector is registered from the
    // next-state decode so the control unit sees a glitch-free one-hot bus
    // that changes only on the clock edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_t_states <= c_NONE;
        end else begin
            r_state    <= w_next_state;
            r_t_states <= w_next_t_states;
        end
    end

    // ------------------------------------------------------------------------
    // Process 2: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (halt && (r_state != S_HALTED)) begin
            // External halt wins over every other transition, including a
            // launch from IDLE requested in the same cycle.
            w_next_state = S_HALTED;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run_mode || step_req) begin
                        w_next_state = S_T0;
                    end
                end
                S_T0: w_next_state = S_T1;
                S_T1: w_next_state = S_T2;
                S_T2: w_next_state = S_T3;
                S_T3: begin
                    if (w_early_end) begin
                        w_next_state = run_mode ? S_T0 : S_IDLE;
                    end else begin
                        w_next_state = S_T4;
                    end
                end
                S_T4: w_next_state = S_T5;
                S_T5: begin
                    if (opcode == HLT_OP) begin
                        w_next_state = S_HALTED;
                    end else begin
                        // run_mode is only consulted at the instruction
                        // boundary, so dropping it mid-instruction lets the
                        // current instruction finish before going IDLE.
                        w_next_state = run_mode ? S_T0 : S_IDLE;
                    end
                end
                S_HALTED: w_next_state = S_HALTED;
                default:  w_next_state = S_IDLE;
            endcase
        end
    end

    // Decode of the state about to be entered, feeding the t_states register
    always_comb begin
        w_next_t_states = c_NONE;
        case (w_next_state)
            S_T0:    w_next_t_states = c_T0;
            S_T1:    w_next_t_states = c_T1;
            S_T2:    w_next_t_states = c_T2;
            S_T3:    w_next_t_states = c_T3;
            S_T4:    w_next_t_states = c_T4;
            S_T5:    w_next_t_states = c_T5;
            default: w_next_t_states = c_NONE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Process 3: output decode from the current state
    // ------------------------------------------------------------------------
    always_comb begin
        w_busy       = 1'b0;
        w_halted     = 1'b0;
        w_instr_done = 1'b0;
        case (r_state)
            S_T0, S_T1, S_T2, S_T4: begin
                w_busy = 1'b1;
            end
            S_T3: begin
                w_busy       = 1'b1;
                w_instr_done = w_early_end;
            end
            S_T5: begin
                w_busy       = 1'b1;
                w_instr_done = 1'b1;
            end
            S_HALTED: begin
                w_halted = 1'b1;
            end
            default: begin
                w_busy       = 1'b0;
                w_halted     = 1'b0;
                w_instr_done = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Busy-cycle counter. Counts every edge taken while a T-state is active
    // and sticks at all-ones rather than wrapping, so a long run never looks
    // like a short one.
    // ------------------------------------------------------------------------
    assign w_cnt_max = &r_cycle_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_count <= '0;
        end else if (w_busy && !w_cnt_max) begin
            r_cycle_count <= r_cycle_count + c_CNT_ONE;
        end
    end

    // ------------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------------
    assign t_states    = r_t_states;
    assign instr_done  = w_instr_done;
    assign busy        = w_busy;
    assign halted      = w_halted;
    assign cycle_count = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_tstate_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tstate_sequencer
// Description : Directed self-checking bench for tstate_sequencer. Three
//               instances share one stimulus: default parameters (u_dut_a),
//               EARLY_END=0 (u_dut_b) and CNT_W=4 (u_dut_c).
// Revision    : 1.0  initial release
// ============================================================================
module tb_tstate_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_mode;
    logic        step_req;
    logic [3:0]  opcode;
    logic        halt;

    logic [5:0]  a_t, b_t, c_t;
    logic        a_done, b_done, c_done;
    logic        a_busy, b_busy, c_busy;
    logic        a_halted, b_halted, c_halted;
    logic [15:0] a_cnt, b_cnt;
    logic [3:0]  c_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tstate_sequencer #(.EARLY_END(1'b1), .HLT_OP(4'b1111), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .run_mode(run_mode), .step_req(step_req),
        .opcode(opcode), .halt(halt), .t_states(a_t), .instr_done(a_done),
        .busy(a_busy), .halted(a_halted), .cycle_count(a_cnt)
    );

    tstate_sequencer #(.EARLY_END(1'b0), .HLT_OP(4'b1111), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst(rst), .run_mode(run_mode), .step_req(step_req),
        .opcode(opcode), .halt(halt), .t_states(b_t), .instr_done(b_done),
        .busy(b_busy), .halted(b_halted), .cycle_count(b_cnt)
    );

    tstate_sequencer #(.EARLY_END(1'b1), .HLT_OP(4'b1111), .CNT_W(4)) u_dut_c (
        .clk(clk), .rst(rst), .run_mode(run_mode), .step_req(step_req),
        .opcode(opcode), .halt(halt), .t_states(c_t), .instr_done(c_done),
        .busy(c_busy), .halted(c_halted), .cycle_count(c_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [5:0] seq_full  [0:6];
    logic [5:0] seq_early [0:4];
    logic [5:0] ring      [0:5];

    initial begin
        seq_full  = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01};
        seq_early = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h01};
        ring      = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20};

        rst = 1'b1; run_mode = 1'b0; step_req = 1'b0; opcode = 4'h0; halt = 1'b0;
        tick();

        // ---------------- reset state ----------------
        check("rst_t",      {26'd0, a_t},      32'h0);
        check("rst_busy",   {31'd0, a_busy},   32'h0);
        check("rst_halted", {31'd0, a_halted}, 32'h0);
        check("rst_done",   {31'd0, a_done},   32'h0);
        check("rst_cnt",    {16'd0, a_cnt},    32'h0);

        // ---------------- free-run LDA ----------------
        rst = 1'b0; run_mode = 1'b1; opcode = 4'b0000;
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("lda_t%0d", i),    {26'd0, a_t},    {26'd0, seq_full[i]});
            check($sformatf("lda_done%0d", i), {31'd0, a_done}, {31'd0, (i == 5)});
        end
        check("lda_cnt6", {16'd0, a_cnt}, 32'd6);

        // ---------------- early end vs full sequence ----------------
        do_reset();
        run_mode = 1'b1; opcode = 4'b0101;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i < 5) begin
                check($sformatf("early_t%0d", i),    {26'd0, a_t},    {26'd0, seq_early[i]});
                check($sformatf("early_done%0d", i), {31'd0, a_done}, {31'd0, (i == 3)});
            end
            check($sformatf("noearly_t%0d", i),    {26'd0, b_t},    {26'd0, seq_full[i]});
            check($sformatf("noearly_done%0d", i), {31'd0, b_done}, {31'd0, (i == 5)});
        end

        // ---------------- step mode ----------------
        do_reset();
        run_mode = 1'b0; opcode = 4'b0010;
        tick();
        check("step_idle_wait", {26'd0, a_t}, 32'h0);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        check("step1_t0", {26'd0, a_t}, 32'h01);
        for (int i = 1; i < 6; i++) begin
            tick();
            check($sformatf("step1_t%0d", i), {26'd0, a_t}, {26'd0, ring[i]});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("step1_idle_t%0d", i),    {26'd0, a_t},    32'h0);
            check($sformatf("step1_idle_busy%0d", i), {31'd0, a_busy}, 32'h0);
        end
        check("step1_cnt", {16'd0, a_cnt}, 32'd6);
        // second pass, with a stray step_req pulse while in T2
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        check("step2_t0", {26'd0, a_t}, 32'h01);
        tick();
        tick();
        check("step2_t2", {26'd0, a_t}, 32'h04);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        check("step2_t3", {26'd0, a_t}, 32'h08);
        tick();
        tick();
        check("step2_t5", {26'd0, a_t}, 32'h20);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("step2_idle_t%0d", i), {26'd0, a_t},    32'h0);
            check($sformatf("step2_idle_b%0d", i), {31'd0, a_busy}, 32'h0);
        end
        check("step2_cnt", {16'd0, a_cnt}, 32'd12);

        // ---------------- HLT ----------------
        do_reset();
        run_mode = 1'b1; opcode = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("hlt_t%0d", i), {26'd0, a_t}, {26'd0, ring[i]});
        end
        tick();
        check("hlt_enter_t",      {26'd0, a_t},      32'h0);
        check("hlt_enter_halted", {31'd0, a_halted}, 32'h1);
        check("hlt_enter_busy",   {31'd0, a_busy},   32'h0);
        check("hlt_enter_cnt",    {16'd0, a_cnt},    32'd6);
        for (int i = 0; i < 4; i++) begin
            run_mode = i[0];
            step_req = ~i[0];
            tick();
            check($sformatf("hlt_hold_t%0d", i),   {26'd0, a_t},      32'h0);
            check($sformatf("hlt_hold_h%0d", i),   {31'd0, a_halted}, 32'h1);
            check($sformatf("hlt_hold_cnt%0d", i), {16'd0, a_cnt},    32'd6);
        end
        step_req = 1'b0; run_mode = 1'b0;
        do_reset();
        #0;
        check("hlt_rst_halted", {31'd0, a_halted}, 32'h0);
        check("hlt_rst_cnt",    {16'd0, a_cnt},    32'h0);
        check("hlt_rst_t",      {26'd0, a_t},      32'h0);

        // ---------------- external halt in T2 ----------------
        run_mode = 1'b1; opcode = 4'b0000;
        tick(); tick(); tick();
        check("xh_t2", {26'd0, a_t}, 32'h04);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("xh_halted", {31'd0, a_halted}, 32'h1);
        check("xh_t",      {26'd0, a_t},      32'h0);
        tick();
        check("xh_stays", {31'd0, a_halted}, 32'h1);

        // ---------------- reset in T4 ----------------
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        check("rt4_t4", {26'd0, a_t}, 32'h10);
        rst = 1'b1;
        tick();
        rst = 1'b0; run_mode = 1'b0;
        check("rt4_t",      {26'd0, a_t},      32'h0);
        check("rt4_busy",   {31'd0, a_busy},   32'h0);
        check("rt4_halted", {31'd0, a_halted}, 32'h0);
        check("rt4_done",   {31'd0, a_done},   32'h0);
        check("rt4_cnt",    {16'd0, a_cnt},    32'h0);

        // ---------------- halt beats step_req in IDLE ----------------
        halt = 1'b1; step_req = 1'b1;
        tick();
        halt = 1'b0; step_req = 1'b0;
        check("hs_halted", {31'd0, a_halted}, 32'h1);
        check("hs_t",      {26'd0, a_t},      32'h0);

        // ---------------- saturation (CNT_W=4 on u_dut_c) ----------------
        do_reset();
        run_mode = 1'b1; opcode = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("sat_t%0d", i), {26'd0, c_t}, {26'd0, ring[i % 6]});
        end
        check("sat_cnt",    {28'd0, c_cnt}, 32'hF);
        check("sat_cnt_a",  {16'd0, a_cnt}, 32'd19);
        tick();
        check("sat_hold",   {28'd0, c_cnt}, 32'hF);
        check("sat_t_next", {26'd0, c_t},   32'h04);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
